// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches words over imem req/ack, and presents decoded fields.
// The optional fetch timeout and its sticky fetch_err flag are enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter int                PC_W     = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               pc_flag,
  input  logic [PC_W-1:0]    jump_target,
  output logic               instr_valid,
  output logic [3:0]         opcode,
  output logic [5:0]         func,
  output logic [7:0]         imm,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_err,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] ir;
  logic               req_active;
  logic               latch_ir;
  logic               req_block;
  logic               timeout_hit;

  // Handshake: imem_req stays high from REQ until the cycle imem_ack is seen;
  // a word is taken only when imem_req and imem_ack are high together.
  // instr_valid marks the ISSUE cycles; stall=1 holds the instruction there.

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err_q;
  logic       drop_q;

  assign timeout_hit = (state == S_WAIT) && !imem_ack && (wait_cnt == 8'(TIMEOUT - 1));
  assign req_block   = drop_q;
  assign fetch_err   = err_q;

  // drop_q forces the single request-low cycle that follows a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= timeout_hit;
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
      if (state == S_WAIT && !timeout_hit) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign req_block   = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        if (req_block)     state_nxt = S_REQ;
        else if (imem_ack) state_nxt = S_ISSUE;
        else               state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack)         state_nxt = S_ISSUE;
        else if (timeout_hit) state_nxt = S_REQ;
        else                  state_nxt = S_WAIT;
      end
      S_ISSUE: begin
        if (!stall) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // Output logic; the request is gated by rst_n so it drops the instant reset asserts.
  always_comb begin
    req_active  = ((state == S_REQ) && !req_block) || (state == S_WAIT);
    imem_req    = rst_n && req_active;
    latch_ir    = req_active && imem_ack;
    instr_valid = (state == S_ISSUE);
  end

  // Instruction register and program counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
      pc <= RESET_PC;
    end else begin
      if (latch_ir) begin
        ir <= imem_rdata;
      end
      if (state == S_ISSUE && !stall) begin
        pc <= pc_flag ? jump_target : pc + 1'b1;
      end
    end
  end

  assign imem_addr = pc;
  assign opcode    = ir[15:12];
  assign func      = ir[5:0];
  assign imm       = ir[7:0];
  assign state_dbg = state;

endmodule
